// File: rtl/fpu_ss_trace_pkg.sv
// Shared types and default field widths for the FPU subsystem retirement trace buffer.
package fpu_ss_trace_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_CIRCULAR = 2'd2
    } trace_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } trace_state_e;

    localparam int unsigned TRACE_NUM_CH = 2;
    localparam int unsigned TRACE_DATA_W = 32;
    localparam int unsigned TRACE_DEPTH  = 16;
    localparam int unsigned TRACE_TS_W   = 16;
    localparam int unsigned TRACE_CNT_W  = 16;
    localparam int unsigned TRACE_RD_W   = 5;

endpackage

// File: rtl/fpu_ss_trace_rr_arb.sv
// Round-robin arbiter: one-hot grant over N requesters; priority rotates past the last grant.
module fpu_ss_trace_rr_arb #(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   idx_ext;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o   = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx_ext = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx_ext = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (idx_ext >= (PTR_W+1)'(N)) begin
                idx_ext = idx_ext - (PTR_W+1)'(N);
            end
            idx = idx_ext[PTR_W-1:0];
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == PTR_W'(N-1)) ? '0 : idx + 1'b1;
            end
        end
        if (clear_i) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpu_ss_trace_buf.sv
// Multi-channel retirement trace buffer: per-channel skids, round-robin into a flop FIFO.
// state | meaning:  IDLE | not capturing  ;  RUN | capturing, ts running  ;  DONE | one-shot buffer filled
module fpu_ss_trace_buf
    import fpu_ss_trace_pkg::*;
#(
    parameter int unsigned NUM_CH = TRACE_NUM_CH,
    parameter int unsigned DATA_W = TRACE_DATA_W,
    parameter int unsigned DEPTH  = TRACE_DEPTH,
    parameter int unsigned TS_W   = TRACE_TS_W,
    parameter int unsigned CNT_W  = TRACE_CNT_W
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic [1:0]                                        mode_i,
    input  logic                                              clear_i,
    input  logic [NUM_CH-1:0]                                 ch_valid_i,
    input  logic [NUM_CH-1:0]                                 ch_fpr_i,
    input  logic [NUM_CH*TRACE_RD_W-1:0]                      ch_rd_i,
    input  logic [NUM_CH*DATA_W-1:0]                          ch_data_i,
    output logic                                              rd_valid_o,
    input  logic                                              rd_ready_i,
    output logic [TS_W+$clog2(NUM_CH)+1+TRACE_RD_W+DATA_W-1:0] rd_data_o,
    output logic [$clog2(DEPTH):0]                            level_o,
    output logic [CNT_W-1:0]                                  drop_cnt_o,
    output logic [CNT_W-1:0]                                  ovf_cnt_o,
    output logic                                              done_o
);
    localparam int unsigned RD_W    = TRACE_RD_W;
    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned SKID_W  = TS_W + 1 + RD_W + DATA_W;
    localparam int unsigned ENTRY_W = TS_W + CH_W + 1 + RD_W + DATA_W;

    trace_state_e       state_q, state_d;
    logic               circ_q, circ_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [NUM_CH-1:0]  skid_vld_q, skid_vld_d;
    logic [SKID_W-1:0]  skid_q [NUM_CH];
    logic [SKID_W-1:0]  skid_d [NUM_CH];
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d, ovf_cnt_q, ovf_cnt_d;

    logic               run, full, empty, pop, wr_en, overwrite;
    logic [NUM_CH-1:0]  gnt, drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [CNT_W:0]     drop_sum;

    assign run       = (state_q == ST_RUN);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign pop       = rd_ready_i && !empty && !clear_i;
    // A full one-shot buffer never overwrites; leftover skid entries simply wait.
    assign wr_en     = (|skid_vld_q) && (state_q != ST_DONE) && !clear_i && (!full || pop || circ_q);
    assign overwrite = wr_en && full && !pop;

    fpu_ss_trace_rr_arb #(
        .N (NUM_CH)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .en_i    (wr_en),
        .req_i   (skid_vld_q),
        .gnt_o   (gnt)
    );

    always_comb begin
        wr_entry   = '0;
        skid_vld_d = skid_vld_q;
        drop       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            skid_d[c] = skid_q[c];
            if (gnt[c]) begin
                wr_entry      = {skid_q[c][SKID_W-1 -: TS_W], CH_W'(c), skid_q[c][SKID_W-TS_W-1:0]};
                skid_vld_d[c] = 1'b0;
            end
            if (run && ch_valid_i[c]) begin
                if (!skid_vld_q[c] || gnt[c]) begin
                    skid_d[c]     = {ts_q, ch_fpr_i[c], ch_rd_i[c*RD_W +: RD_W], ch_data_i[c*DATA_W +: DATA_W]};
                    skid_vld_d[c] = 1'b1;
                end else begin
                    drop[c] = 1'b1;
                end
            end
        end

        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'($countones(drop));
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        ovf_cnt_d  = ovf_cnt_q;
        if (overwrite && !(&ovf_cnt_q)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end

        level_d = level_q;
        if (wr_en && !pop && !full) begin
            level_d = level_q + 1'b1;
        end else if (pop && !wr_en) begin
            level_d = level_q - 1'b1;
        end
        head_d = (pop || overwrite) ? head_q + 1'b1 : head_q;
        tail_d = wr_en ? tail_q + 1'b1 : tail_q;
        ts_d   = run ? ts_q + 1'b1 : ts_q;

        if (clear_i) begin
            skid_vld_d = '0;
            drop_cnt_d = '0;
            ovf_cnt_d  = '0;
            level_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            ts_d       = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        circ_d  = circ_q;
        case (state_q)
            ST_IDLE: begin
                if (mode_i == MODE_ONESHOT) begin
                    state_d = ST_RUN;
                    circ_d  = 1'b0;
                end else if (mode_i == MODE_CIRCULAR) begin
                    state_d = ST_RUN;
                    circ_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!circ_q && wr_en && level_d == LVL_W'(DEPTH)) begin
                    state_d = ST_DONE;
                end else if (mode_i != MODE_ONESHOT && mode_i != MODE_CIRCULAR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            circ_q     <= 1'b0;
            ts_q       <= '0;
            skid_vld_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                skid_q[c] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            circ_q     <= circ_d;
            ts_q       <= ts_d;
            skid_vld_q <= skid_vld_d;
            for (int c = 0; c < NUM_CH; c++) begin
                skid_q[c] <= skid_d[c];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // Entry storage needs no reset: level_q masks stale slots.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

    assign rd_valid_o = !empty;
    assign rd_data_o  = empty ? '0 : mem_q[head_q];
    assign level_o    = level_q;
    assign drop_cnt_o = drop_cnt_q;
    assign ovf_cnt_o  = ovf_cnt_q;
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_fpu_ss_trace_buf.sv
// Self-checking bench for fpu_ss_trace_buf: directed vector table, multi-cycle sequences, random vs queue model.
module tb_fpu_ss_trace_buf;
    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 16;
    localparam int TS_W    = 16;
    localparam int CNT_W   = 16;
    localparam int ENTRY_W = TS_W + 1 + 1 + 5 + DATA_W;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic [1:0]         mode_i = 2'd0;
    logic               clear_i = 1'b0;
    logic [1:0]         ch_valid_i = 2'b00;
    logic [1:0]         ch_fpr_i = 2'b00;
    logic [9:0]         ch_rd_i = 10'd0;
    logic [63:0]        ch_data_i = 64'd0;
    logic               rd_valid_o;
    logic               rd_ready_i = 1'b0;
    logic [ENTRY_W-1:0] rd_data_o;
    logic [4:0]         level_o;
    logic [15:0]        drop_cnt_o;
    logic [15:0]        ovf_cnt_o;
    logic               done_o;

    int n_checks = 0;
    int n_pass   = 0;

    fpu_ss_trace_buf dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .mode_i     (mode_i),
        .clear_i    (clear_i),
        .ch_valid_i (ch_valid_i),
        .ch_fpr_i   (ch_fpr_i),
        .ch_rd_i    (ch_rd_i),
        .ch_data_i  (ch_data_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_data_o  (rd_data_o),
        .level_o    (level_o),
        .drop_cnt_o (drop_cnt_o),
        .ovf_cnt_o  (ovf_cnt_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: state 0=idle 1=run 2=done; skids and buffer as plain queues.
    int                 m_state, m_rr, m_ts, m_drop, m_ovf;
    bit                 m_circ;
    bit                 m_skid_full [NUM_CH];
    logic [ENTRY_W-1:0] m_skid [NUM_CH];
    logic [ENTRY_W-1:0] m_buf [$];

    function automatic void model_reset();
        m_state = 0; m_rr = 0; m_ts = 0; m_drop = 0; m_ovf = 0; m_circ = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_skid_full[c] = 1'b0;
            m_skid[c]      = '0;
        end
        m_buf.delete();
    endfunction

    function automatic void model_step();
        int  g, c, prev;
        bit  pop;
        if (clear_i) begin
            model_reset();
            return;
        end
        pop = rd_ready_i && (m_buf.size() > 0);
        g   = -1;
        if (m_state != 2 && (m_buf.size() < DEPTH || pop || m_circ)) begin
            for (int k = 0; k < NUM_CH; k++) begin
                c = (m_rr + k) % NUM_CH;
                if (g < 0 && m_skid_full[c]) g = c;
            end
        end
        if (pop) void'(m_buf.pop_front());
        if (g >= 0) begin
            if (m_buf.size() == DEPTH) begin
                void'(m_buf.pop_front());
                if (m_ovf < MAXC) m_ovf++;
            end
            m_buf.push_back(m_skid[g]);
            m_skid_full[g] = 1'b0;
            m_rr = (g + 1) % NUM_CH;
        end
        if (m_state == 1) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_valid_i[k]) begin
                    if (!m_skid_full[k]) begin
                        m_skid[k] = {TS_W'(m_ts), 1'(k), ch_fpr_i[k], ch_rd_i[k*5 +: 5], ch_data_i[k*32 +: 32]};
                        m_skid_full[k] = 1'b1;
                    end else if (m_drop < MAXC) begin
                        m_drop++;
                    end
                end
            end
        end
        prev = m_state;
        if (m_state == 0) begin
            if (mode_i == 2'd1) begin m_state = 1; m_circ = 1'b0; end
            else if (mode_i == 2'd2) begin m_state = 1; m_circ = 1'b1; end
        end else if (m_state == 1) begin
            if (!m_circ && g >= 0 && m_buf.size() == DEPTH) m_state = 2;
            else if (mode_i != 2'd1 && mode_i != 2'd2) m_state = 0;
        end
        if (prev == 1) m_ts = (m_ts + 1) % (1 << TS_W);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic compare_model();
        logic               e_valid;
        logic [ENTRY_W-1:0] e_data;
        e_valid = (m_buf.size() > 0);
        e_data  = e_valid ? m_buf[0] : '0;
        chk("model_cycle",
            {rd_valid_o, rd_data_o, level_o, drop_cnt_o, ovf_cnt_o, done_o},
            {e_valid, e_data, 5'(m_buf.size()), 16'(m_drop), 16'(m_ovf), (m_state == 2)});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        compare_model();
    endtask

    typedef struct {
        logic [1:0]         mode;
        logic               clr;
        logic [1:0]         vld;
        logic               rdy;
        logic               e_valid;
        logic [4:0]         e_level;
        logic [15:0]        e_drop;
        logic               e_done;
        logic               chk_data;
        logic [ENTRY_W-1:0] e_data;
    } vec_t;

    function automatic vec_t row(input logic [1:0] mode, input logic clr, input logic [1:0] vld,
                                 input logic rdy, input logic v, input logic [4:0] lvl,
                                 input logic [15:0] drp, input logic dn);
        vec_t r;
        r.mode = mode; r.clr = clr; r.vld = vld; r.rdy = rdy;
        r.e_valid = v; r.e_level = lvl; r.e_drop = drp; r.e_done = dn;
        r.chk_data = 1'b0; r.e_data = '0;
        return r;
    endfunction

    vec_t tbl [21];

    initial begin
        for (int i = 0; i < 6; i++) tbl[i] = row(2'd2, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
        tbl[6]  = row(2'd2, 1'b0, 2'b01, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
        tbl[7]  = row(2'd2, 1'b0, 2'b00, 1'b0, 1'b1, 5'd1, 16'd0, 1'b0);
        tbl[7].chk_data = 1'b1;
        tbl[7].e_data   = {16'd5, 1'b0, 1'b1, 5'd3, 32'h3F80_0000};
        tbl[8]  = row(2'd2, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0, 16'd0, 1'b0);
        tbl[9]  = row(2'd2, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
        tbl[10] = row(2'd2, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
        tbl[11] = row(2'd2, 1'b0, 2'b11, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
        tbl[12] = row(2'd2, 1'b0, 2'b11, 1'b0, 1'b1, 5'd1, 16'd1, 1'b0);
        tbl[12].chk_data = 1'b1;
        tbl[12].e_data   = {16'd0, 1'b0, 1'b1, 5'd3, 32'h3F80_0000};
        tbl[13] = row(2'd2, 1'b0, 2'b11, 1'b0, 1'b1, 5'd2, 16'd2, 1'b0);
        tbl[14] = row(2'd2, 1'b0, 2'b11, 1'b0, 1'b1, 5'd3, 16'd3, 1'b0);
        tbl[15] = row(2'd2, 1'b0, 2'b00, 1'b0, 1'b1, 5'd4, 16'd3, 1'b0);
        tbl[16] = row(2'd2, 1'b0, 2'b00, 1'b0, 1'b1, 5'd5, 16'd3, 1'b0);
        tbl[17] = row(2'd2, 1'b0, 2'b00, 1'b0, 1'b1, 5'd5, 16'd3, 1'b0);
        tbl[18] = row(2'd2, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
        tbl[19] = row(2'd0, 1'b0, 2'b11, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);
        tbl[20] = row(2'd0, 1'b0, 2'b11, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0);

        ch_fpr_i  = 2'b01;
        ch_rd_i   = {5'd7, 5'd3};
        ch_data_i = {32'h4049_0FDB, 32'h3F80_0000};
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("reset_outputs", {rd_valid_o, rd_data_o, level_o, drop_cnt_o, ovf_cnt_o, done_o}, '0);
        rst_ni = 1'b1;
        compare_model();

        for (int i = 0; i < 21; i++) begin
            mode_i     = tbl[i].mode;
            clear_i    = tbl[i].clr;
            ch_valid_i = tbl[i].vld;
            rd_ready_i = tbl[i].rdy;
            tick();
            chk("tbl_row", {rd_valid_o, level_o, drop_cnt_o, ovf_cnt_o, done_o},
                {tbl[i].e_valid, tbl[i].e_level, tbl[i].e_drop, 16'd0, tbl[i].e_done});
            if (tbl[i].chk_data) chk("tbl_data", rd_data_o, tbl[i].e_data);
        end
        ch_valid_i = 2'b00; rd_ready_i = 1'b0; clear_i = 1'b0;

        // One-shot fill: 20 events, 16 fit, rest ignored once done.
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        mode_i = 2'd1; tick();
        for (int i = 0; i < 20; i++) begin
            ch_valid_i = 2'b01;
            ch_data_i[31:0] = 32'hA000_0000 + 32'(i);
            tick();
            if (i == 15) chk("oneshot_pre_full", {level_o, done_o}, {5'd15, 1'b0});
            ch_valid_i = 2'b00;
            tick();
        end
        chk("oneshot_full", {level_o, done_o, ovf_cnt_o, drop_cnt_o}, {5'd16, 1'b1, 16'd0, 16'd0});
        chk("oneshot_head", rd_data_o[31:0], 32'hA000_0000);
        mode_i = 2'd0; tick();
        chk("oneshot_hold", {done_o, level_o}, {1'b1, 5'd16});
        rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
        chk("done_pop", {level_o, done_o, rd_data_o[31:0]}, {5'd15, 1'b1, 32'hA000_0001});

        // Circular wrap: 20 events, no pops.
        clear_i = 1'b1; mode_i = 2'd2; tick(); clear_i = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            ch_valid_i = 2'b01;
            ch_data_i[31:0] = 32'hB000_0000 + 32'(i);
            tick();
            ch_valid_i = 2'b00;
            tick();
        end
        chk("circ_wrap", {level_o, ovf_cnt_o, drop_cnt_o, done_o}, {5'd16, 16'd4, 16'd0, 1'b0});
        chk("circ_head", rd_data_o[31:0], 32'hB000_0004);

        // Full circular buffer: write and pop in the same cycle.
        ch_valid_i = 2'b01; ch_data_i[31:0] = 32'hC000_0000; tick();
        ch_valid_i = 2'b00; rd_ready_i = 1'b1;
        chk("pushpop_oldest", rd_data_o[31:0], 32'hB000_0004);
        tick(); rd_ready_i = 1'b0;
        chk("pushpop", {level_o, ovf_cnt_o, rd_data_o[31:0]}, {5'd16, 16'd4, 32'hB000_0005});

        // Random traffic against the model, with an async reset pulse midway.
        mode_i = 2'd2;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) mode_i = 2'($urandom_range(0, 3));
            clear_i    = ($urandom_range(0, 99) == 0);
            ch_valid_i = 2'($urandom);
            ch_fpr_i   = 2'($urandom);
            ch_rd_i    = 10'($urandom);
            ch_data_i  = {$urandom, $urandom};
            rd_ready_i = ($urandom_range(0, 2) == 0);
            if (n == 700) begin
                #2 rst_ni = 1'b0;
                #1 chk("async_reset", {rd_valid_o, rd_data_o, level_o, drop_cnt_o, ovf_cnt_o, done_o}, '0);
                model_reset();
                @(posedge clk_i);
                @(negedge clk_i);
                rst_ni = 1'b1;
                compare_model();
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
